// File: rtl/efuse_pkg.sv
// Shared types and constants for the eFuse trim shadow block.
// The state encoding is private to the shadow FSM; consumers see only its status flags.
package efuse_pkg;

    localparam int EFUSE_BITS   = 256;
    localparam int CHK_BYTE_IDX = 31;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        CMP,
        DONE,
        FAIL
    } shadow_state_e;

endpackage

// File: rtl/efuse_chksum8.sv
// Serial mod-256 byte accumulator: clr zeroes the sum, en adds byte_in.
// Latency: sum reflects a byte one cycle after it is presented with en.
// Backpressure: none; it accepts one byte per enabled cycle.
module efuse_chksum8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] byte_in,
    output logic [7:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum + byte_in;
        end
    end

endmodule

// File: rtl/efuse_trim_shadow.sv
// Shadows the eFuse autoload image, checks slot coverage and the byte-31 checksum.
// Latency: autoload_done in cycle T -> trim_vld/chk_err from T+33; load_err from T+1.
// Backpressure: none; words arrive as pulses. EFUSE_SHADOW_LOCK_EN freezes DONE until rst.
module efuse_trim_shadow
    import efuse_pkg::*;
#(
    parameter  int NR    = 64,
    localparam int NSLOT = EFUSE_BITS / NR,
    localparam int SELW  = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  word_vld,
    input  logic [SELW-1:0]       word_sel,
    input  logic [NR-1:0]         word_data,
    input  logic                  autoload_done,
    input  logic                  autoload_vld,
    output logic [EFUSE_BITS-1:0] shadow_data,
    output logic                  trim_vld,
    output logic                  chk_err,
    output logic                  load_err,
    output logic                  busy
);

    shadow_state_e    state;
    logic [NSLOT-1:0] bitmap;
    logic [NSLOT-1:0] wr_mask;
    logic [NSLOT-1:0] bitmap_upd;
    logic [4:0]       cnt;
    logic [7:0]       sum8;
    logic [7:0]       cur_byte;
    logic             lock_hold;
    logic             start_acc;
    logic             capture;

`ifdef EFUSE_SHADOW_LOCK_EN
    assign lock_hold = (state == DONE);
`else
    assign lock_hold = 1'b0;
`endif

    assign start_acc = load_start & ~lock_hold;
    // A word arriving with an accepted load_start lands in the fresh image.
    assign capture   = word_vld & (start_acc | (state == COLLECT));

    always_comb begin
        wr_mask = '0;
        for (int s = 0; s < NSLOT; s++) begin
            wr_mask[s] = (word_sel == SELW'(s));
        end
    end

    assign bitmap_upd = bitmap | (capture ? wr_mask : '0);
    assign cur_byte   = shadow_data[{cnt, 3'b000} +: 8];

    efuse_chksum8 u_chksum (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == COLLECT),
        .en      (state == CHECK),
        .byte_in (cur_byte),
        .sum     (sum8)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bitmap      <= '0;
            shadow_data <= '0;
            cnt         <= 5'd0;
            trim_vld    <= 1'b0;
            chk_err     <= 1'b0;
            load_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (capture) begin
                for (int s = 0; s < NSLOT; s++) begin
                    if (wr_mask[s]) begin
                        shadow_data[s*NR +: NR] <= word_data;
                    end
                end
            end

            if (start_acc) begin
                state    <= COLLECT;
                bitmap   <= word_vld ? wr_mask : '0;
                cnt      <= 5'd0;
                trim_vld <= 1'b0;
                chk_err  <= 1'b0;
                load_err <= 1'b0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    COLLECT: begin
                        bitmap <= bitmap_upd;
                        if (autoload_done) begin
                            if (autoload_vld && (&bitmap_upd)) begin
                                state <= CHECK;
                                cnt   <= 5'd0;
                            end else begin
                                state    <= FAIL;
                                load_err <= 1'b1;
                                busy     <= 1'b0;
                            end
                        end
                    end
                    CHECK: begin
                        if (cnt == 5'(CHK_BYTE_IDX - 1)) begin
                            state <= CMP;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    CMP: begin
                        busy <= 1'b0;
                        if (shadow_data[CHK_BYTE_IDX*8 +: 8] == ~sum8) begin
                            state    <= DONE;
                            trim_vld <= 1'b1;
                        end else begin
                            state   <= FAIL;
                            chk_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_efuse_trim_shadow.sv
// Directed bench for efuse_trim_shadow with a cycle-indexed reference model.
module tb_efuse_trim_shadow;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_start = 1'b0;
    logic         word_vld = 1'b0;
    logic [1:0]   word_sel = 2'd0;
    logic [63:0]  word_data = 64'd0;
    logic         autoload_done = 1'b0;
    logic         autoload_vld = 1'b0;
    logic [255:0] shadow_data;
    logic         trim_vld, chk_err, load_err, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    efuse_trim_shadow #(.NR(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .word_vld      (word_vld),
        .word_sel      (word_sel),
        .word_data     (word_data),
        .autoload_done (autoload_done),
        .autoload_vld  (autoload_vld),
        .shadow_data   (shadow_data),
        .trim_vld      (trim_vld),
        .chk_err       (chk_err),
        .load_err      (load_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: image as bytes, filled slots as flags, verdict scheduled by cycle number.
    logic [7:0] mb[32];
    bit         mf[4];
    bit         m_coll, m_trim, m_chk, m_lerr, m_busy, m_lock;
    int         m_verd = -1;

    initial begin
        for (int i = 0; i < 32; i++) mb[i] = 8'h00;
        for (int i = 0; i < 4; i++) mf[i] = 1'b0;
        {m_coll, m_trim, m_chk, m_lerr, m_busy, m_lock} = '0;
    end

    always @(posedge clk) begin
        int  k;
        bit  all;
        int  sum;
        k = cyc;
        cyc = cyc + 1;
        if (rst) begin
            for (int i = 0; i < 32; i++) mb[i] = 8'h00;
            for (int i = 0; i < 4; i++) mf[i] = 1'b0;
            {m_coll, m_trim, m_chk, m_lerr, m_busy, m_lock} = '0;
            m_verd = -1;
        end else if (load_start && !m_lock) begin
            m_coll = 1; m_verd = -1;
            for (int i = 0; i < 4; i++) mf[i] = 1'b0;
            m_trim = 0; m_chk = 0; m_lerr = 0; m_busy = 1;
            if (word_vld) begin
                for (int b = 0; b < 8; b++) mb[int'(word_sel)*8 + b] = word_data[8*b +: 8];
                mf[word_sel] = 1'b1;
            end
        end else if (m_coll) begin
            if (word_vld) begin
                for (int b = 0; b < 8; b++) mb[int'(word_sel)*8 + b] = word_data[8*b +: 8];
                mf[word_sel] = 1'b1;
            end
            if (autoload_done) begin
                m_coll = 0;
                all = 1;
                for (int i = 0; i < 4; i++) all = all & mf[i];
                if (autoload_vld && all) m_verd = k + 33;
                else begin m_lerr = 1; m_busy = 0; end
            end
        end else if (m_verd == k + 1) begin
            sum = 0;
            for (int i = 0; i < 31; i++) sum = sum + int'(mb[i]);
            m_busy = 0; m_verd = -1;
            if (mb[31] == ~8'(sum)) begin
                m_trim = 1;
`ifdef EFUSE_SHADOW_LOCK_EN
                m_lock = 1;
`endif
            end else m_chk = 1;
        end
    end

    always @(negedge clk) begin
        logic [255:0] exp_img;
        for (int i = 0; i < 32; i++) exp_img[8*i +: 8] = mb[i];
        chk("model_shadow", shadow_data, exp_img);
        chk("model_trim_vld", {255'd0, trim_vld}, {255'd0, m_trim});
        chk("model_chk_err", {255'd0, chk_err}, {255'd0, m_chk});
        chk("model_load_err", {255'd0, load_err}, {255'd0, m_lerr});
        chk("model_busy", {255'd0, busy}, {255'd0, m_busy});
    end

    function automatic logic [255:0] make_img(input int seed);
        logic [255:0] v;
        logic [7:0]   s;
        s = 8'h00;
        for (int i = 0; i < 31; i++) begin
            v[8*i +: 8] = 8'(seed + i * 7 + 3);
            s = s + v[8*i +: 8];
        end
        v[255:248] = ~s;
        return v;
    endfunction

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [255:0] img, input logic [3:0] mask, input logic vld,
                           input bit merge, output int t);
        t = -1;
        @(negedge clk);
        load_start = 1'b1;
        if (merge) begin word_vld = 1'b1; word_sel = 2'd0; word_data = img[63:0]; end
        @(negedge clk);
        load_start = 1'b0; word_vld = 1'b0;
        for (int s = (merge ? 1 : 0); s < 4; s++) begin
            if (mask[s]) begin
                word_vld = 1'b1; word_sel = 2'(s); word_data = img[s*64 +: 64];
                if (merge && s == 3) begin autoload_done = 1'b1; autoload_vld = vld; t = cyc; end
                @(negedge clk);
                word_vld = 1'b0; autoload_done = 1'b0;
            end
        end
        if (!merge) begin
            autoload_done = 1'b1; autoload_vld = vld; t = cyc;
            @(negedge clk);
            autoload_done = 1'b0;
        end
    endtask

    logic [255:0] img1, img2, img3;
    int t;

    initial begin
        img1 = {8'hE0, {31{8'h01}}};
        img2 = {8'hE1, {31{8'h01}}};
        img3 = make_img(17);

        repeat (2) @(negedge clk);
        chk("reset_shadow", shadow_data, 256'd0);
        chk("reset_flags", {252'd0, trim_vld, chk_err, load_err, busy}, 256'd0);
        rst = 1'b0;

        // Good image: verdict lands exactly at T+33; a stray word in CHECK is ignored.
        do_load(img1, 4'hF, 1'b1, 1'b0, t);
        wait_cyc(t + 5);
        word_vld = 1'b1; word_sel = 2'd0; word_data = '1;
        @(negedge clk);
        word_vld = 1'b0;
        wait_cyc(t + 32);
        chk("good_t32_trim", {255'd0, trim_vld}, 256'd0);
        chk("good_t32_busy", {255'd0, busy}, 256'd1);
        wait_cyc(t + 33);
        chk("good_t33_trim", {255'd0, trim_vld}, 256'd1);
        chk("good_t33_errs", {254'd0, chk_err, load_err}, 256'd0);
        chk("good_shadow", shadow_data, {8'hE0, {31{8'h01}}});

        // Bad checksum byte.
        do_reset();
        do_load(img2, 4'hF, 1'b1, 1'b0, t);
        wait_cyc(t + 33);
        chk("badsum_chk_err", {255'd0, chk_err}, 256'd1);
        chk("badsum_trim", {255'd0, trim_vld}, 256'd0);

        // Missing slot 2.
        do_reset();
        do_load(img1, 4'b1011, 1'b1, 1'b0, t);
        wait_cyc(t + 1);
        chk("missing_load_err", {255'd0, load_err}, 256'd1);
        chk("missing_busy", {255'd0, busy}, 256'd0);

        // Blank fuse.
        do_reset();
        do_load(256'd0, 4'hF, 1'b1, 1'b0, t);
        wait_cyc(t + 33);
        chk("blank_chk_err", {255'd0, chk_err}, 256'd1);

        // Controller-reported failure on a full bitmap.
        do_reset();
        do_load(img1, 4'hF, 1'b0, 1'b0, t);
        wait_cyc(t + 1);
        chk("avld0_load_err", {255'd0, load_err}, 256'd1);

        // Reset in the middle of CHECK, then a good load with merged start/done words.
        do_reset();
        do_load(img1, 4'hF, 1'b1, 1'b0, t);
        wait_cyc(t + 11);
        #2 rst = 1'b1;
        #1;
        chk("midrst_shadow", shadow_data, 256'd0);
        chk("midrst_flags", {252'd0, trim_vld, chk_err, load_err, busy}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        do_load(img3, 4'hF, 1'b1, 1'b1, t);
        wait_cyc(t + 33);
        chk("merged_trim", {255'd0, trim_vld}, 256'd1);

        // load_start during CHECK abandons it and restarts on the new image.
        do_reset();
        do_load(img2, 4'hF, 1'b1, 1'b0, t);
        wait_cyc(t + 6);
        do_load(img1, 4'hF, 1'b1, 1'b0, t);
        wait_cyc(t + 33);
        chk("restart_trim", {255'd0, trim_vld}, 256'd1);
        chk("restart_chk_err", {255'd0, chk_err}, 256'd0);

        // Second load_start from DONE.
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
`ifdef EFUSE_SHADOW_LOCK_EN
        chk("lock_trim", {255'd0, trim_vld}, 256'd1);
        chk("lock_busy", {255'd0, busy}, 256'd0);
        word_vld = 1'b1; word_sel = 2'd1; word_data = '0;
        @(negedge clk);
        word_vld = 1'b0;
        @(negedge clk);
        chk("lock_shadow", shadow_data, {8'hE0, {31{8'h01}}});
`else
        chk("reload_trim", {255'd0, trim_vld}, 256'd0);
        chk("reload_busy", {255'd0, busy}, 256'd1);
        chk("reload_shadow_kept", shadow_data, {8'hE0, {31{8'h01}}});
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/efuse_trim_shadow.md
Name: efuse_trim_shadow

Overview:
- Sits directly downstream of the eFuse controller's autoload path.
- Captures each NR-bit word the controller returns during autoload into a 256-bit shadow register.
- On autoload completion, checks that every slot was filled and verifies an 8-bit checksum byte.
- Publishes the validated shadow image and status flags to trim consumers and the register file.

Parameters:
- NR, 64, read word width in bits; must divide 256.
- NSLOT, 256/NR, number of word slots (derived, not overridable).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- load_start  input  1  pulse; autoload sequence begins (pmu_efuse_start or autoload-mode rg_efuse_start)
- word_vld  input  1  pulse; word_data/word_sel valid (controller read_done)
- word_sel  input  $clog2(NSLOT)  slot index of word_data
- word_data  input  NR  read word
- autoload_done  input  1  pulse; controller finished autoload
- autoload_vld  input  1  qualifies autoload_done; 0 = controller-reported failure
- shadow_data  output  256  captured eFuse image
- trim_vld  output  1  image complete and checksum good
- chk_err  output  1  checksum mismatch (sticky until next load_start)
- load_err  output  1  missing slot(s) or autoload_vld=0 (sticky until next load_start)
- busy  output  1  state != IDLE/DONE/FAIL

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high. Reset values:
  - shadow_data=0, slot bitmap=0
  - trim_vld=0, chk_err=0, load_err=0, busy=0
  - state=IDLE
- Reset mid-operation aborts everything to the reset values; there is no partial retention.
- FSM states: IDLE, COLLECT, CHECK, CMP, DONE, FAIL.
- Transitions:
  - IDLE/DONE/FAIL --load_start--> COLLECT. On entry: clear bitmap, trim_vld, chk_err, load_err. shadow_data is retained until overwritten.
  - COLLECT --autoload_done & autoload_vld & bitmap all-ones--> CHECK.
  - COLLECT --autoload_done & (!autoload_vld | bitmap not all-ones)--> FAIL, with load_err=1.
  - CHECK: 5-bit counter runs 0..30, one byte per cycle; sum8 += shadow_data[8*cnt +: 8] (mod 256). After cnt=30 --> CMP.
  - CMP: if shadow_data[255:248] == ~sum8 --> DONE with trim_vld=1; else --> FAIL with chk_err=1.
- Latency: autoload_done sampled in cycle T gives CHECK over T+1..T+31, CMP at T+32, and trim_vld/chk_err high from T+33.
- Word capture (COLLECT only): word_vld writes shadow_data[word_sel*NR +: NR] and sets bitmap[word_sel].
  - A duplicate slot write overwrites silently.
  - word_vld in any other state is ignored.
- Simultaneous events:
  - load_start with word_vld in the same cycle: the clear applies and the word is captured (bitmap bit set).
  - autoload_done with word_vld in COLLECT: the word is captured and included in the completeness check of that same cycle.
  - load_start during COLLECT/CHECK/CMP: restart COLLECT and abandon the current check.
- Blank fuse (all zero) fails the checksum, since ~0=FF≠00, so chk_err=1.
- Checksum rule: byte 31 = bitwise NOT of the mod-256 sum of bytes 0..30.

Optional Feature:
- Macro EFUSE_SHADOW_LOCK_EN.
- Defined: once DONE is reached, load_start and word_vld are ignored until rst. The image and trim_vld are frozen.
- Undefined: load_start from DONE re-enters COLLECT as above.

Decomposition:
- Package efuse_pkg holds:
  - typedef enum shadow_state_e {IDLE,COLLECT,CHECK,CMP,DONE,FAIL}
  - localparam EFUSE_BITS=256
  - localparam CHK_BYTE_IDX=31
- Sub-module efuse_chksum8 is a serial byte accumulator with clr/en/byte_in and sum output, instantiated once.

Test Plan:
- NR=64, load_start, 4 words (sel 0..3) with bytes 0..30 = 0x01 and byte31 = ~0x1F = 0xE0, autoload_done & vld=1 -> trim_vld=1 at T+33, chk_err=0, load_err=0, shadow_data matches.
- Same as above with byte31 = 0xE1 -> chk_err=1, trim_vld=0, FSM in FAIL.
- Words sent to sel 0,1,3 only, then autoload_done -> load_err=1 at T+1, no CHECK cycles, busy=0.
- All-zero image -> chk_err=1. Separately, autoload_done with autoload_vld=0 on a full bitmap -> load_err=1.
- Assert rst during CHECK (cnt=10) -> all outputs 0 immediately, state IDLE; a subsequent good load passes.
- DONE then second load_start: with EFUSE_SHADOW_LOCK_EN, image unchanged and trim_vld stays 1; without it, bitmap cleared, trim_vld=0 and busy=1 next cycle.
